spi_slave_ri: RTL and testbench
===============================

// Module: spi_slave_ri
// PURPOSE
//  CPU-mapped SPI slave (target) peripheral: the responder end of the SPI bus driven by the
//  team's SPI master peripheral. Oversamples the external sclk/mosi/ncs in the system clock
//  domain, shifts one byte per 8 sclk edges and exchanges bytes with the CPU through a
//  4-register port. Raises a level interrupt on received-byte and transmit-empty.
// PARAMETERS
//  SYNC_STAGES  2      flops in each sclk/mosi/ncs input synchronizer (>=2)
//  IDLE_FILL    8'hFF  byte shifted out when the CPU has not supplied TX data (underrun)
// PORTS
//  clk       in   1  system clock; external sclk must be <= clk/8
//  reset     in   1  asynchronous, active-high reset
//  a         in   2  register address
//  ce        in   1  chip enable for CPU access
//  wren      in   1  write strobe (with ce); ce & ~wren = read access
//  from_cpu  in   8  CPU write data
//  to_cpu    out  8  registered CPU read data
//  spi_int   out  1  level interrupt
//  sclk      in   1  SPI clock from master
//  mosi      in   1  master-out data
//  ncs       in   1  active-low slave select
//  miso      out  1  slave-out data
//  miso_oe   out  1  miso output enable (1 while selected); pad tri-states when 0
// BEHAVIOUR
//  Registers: 0 DATA (rd: rx_data, wr: tx_data), 1 STATUS, 2 CONTROL, 3 BYTE_COUNT (rd only).
//  STATUS rd: {SELECTED,3'b000,UNDERRUN,OVERRUN,TX_EMPTY,RX_FULL}; wr 1 to bit2/bit3 clears
//   OVERRUN/UNDERRUN, other bits ignored.  CONTROL: bit0 CPOL, bit1 CPHA, bit2 RX_IE, bit3 TX_IE.
//  Reset: to_cpu=0, miso=0, miso_oe=0, cpol=cpha=0, IEs=0, rx_data=0, tx_data=IDLE_FILL,
//   tx_valid=0, rx_full=0, flags=0, bit_cnt=0, byte_count=0, synchronizers preset idle (ncs=1).
//  to_cpu: updated every clk from a (1-cycle read latency), like the other ri peripherals.
//  Sync: SYNC_STAGES flops + 1 edge-detect flop; SPI events act SYNC_STAGES+1 clks after pins.
//  States: IDLE (ncs_s=1) -> SELECT on ncs_s fall -> SHIFT -> back to IDLE on ncs_s rise.
//   SELECT (1 clk): bit_cnt=0, byte_count=0, shifter <= tx_valid ? tx_data : IDLE_FILL,
//   tx_valid cleared; UNDERRUN set if tx_valid was 0. miso_oe=1 from this clk until ncs_s=1.
//  Leading edge = sclk_s leaving CPOL level; trailing = returning to it.
//   CPHA=0: sample mosi on leading, shift miso on trailing; MSB on miso from SELECT.
//   CPHA=1: shift on leading (first leading edge presents MSB), sample on trailing.
//  miso = shifter[7]; MSB first both directions. Sample inserts at bit0; bit_cnt counts samples.
//  On 8th sample: rx_data <= byte, rx_full=1, byte_count++ (saturates 255), bit_cnt=0,
//   shifter reloads as in SELECT (tx_valid/UNDERRUN rules identical). OVERRUN set if rx_full
//   was already 1 and not being cleared the same clk; rx_data is overwritten regardless.
//  CPU read of DATA (ce&~wren&a==0) clears rx_full; if a byte completes that same clk,
//   rx_full stays 1 and no OVERRUN.  CPU write of DATA sets tx_valid=1; a reload in the same
//   clk uses the pre-write state (so may underrun) and the new byte stays pending.
//  CONTROL writes while SELECTED are ignored (IE bits included? no: IE bits always writable;
//   CPOL/CPHA only while IDLE).
//  ncs_s rise mid-byte: partial byte discarded, bit_cnt=0, rx_full/rx_data unchanged,
//   preloaded tx byte is lost (not restored to tx_valid). miso_oe=0 next clk.
//  spi_int = (RX_IE & rx_full) | (TX_IE & ~tx_valid); level, combinational from flops.
//  Reset asserted mid-transfer: all state to reset values immediately; transfer resumes only
//   after a fresh ncs fall.
// TESTING
//  1 Mode0, tx=0x3C preloaded, master sends 0xA5 -> rx_data=0xA5, master got 0x3C, RX_FULL=1,
//    spi_int=1 with RX_IE, byte_count=1.
//  2 Modes 1/2/3 each: 3-byte burst tx 0x11,0x22,0x33 refilled on TX_EMPTY, rx 0x81,0x42,0x24
//    -> all bytes match both ways, byte_count=3, no flags.
//  3 No tx preload, send 0x00 -> master reads 0xFF (IDLE_FILL), UNDERRUN=1; write 0x08 to
//    STATUS -> UNDERRUN=0.
//  4 Two bytes 0x55,0xAA without reading DATA -> OVERRUN=1, rx_data=0xAA; DATA read on the
//    completion clk of byte 2 -> OVERRUN=0, RX_FULL=1.
//  5 ncs deasserted after 5 bits -> RX_FULL unchanged, next full byte 0x96 received intact.
//  6 Async reset pulse mid-byte -> to_cpu=0, miso_oe=0, STATUS reads 0x02 next access.

Source files
------------

// File: rtl/spi_slave_ri.sv
// CPU-mapped SPI target: oversamples sclk/mosi/ncs in the clk domain, shifts one byte per
// 8 sclk edges and exposes DATA/STATUS/CONTROL/BYTE_COUNT through a 4-register port.
module spi_slave_ri #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] a,
  input  logic       ce,
  input  logic       wren,
  input  logic [7:0] from_cpu,
  output logic [7:0] to_cpu,
  output logic       spi_int,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ncs,
  output logic       miso,
  output logic       miso_oe,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SHIFT  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q;
  logic [7:0]             to_cpu_q;
  logic                   miso_oe_q;
  logic                   cpol_q, cpha_q, rx_ie_q, tx_ie_q;
  logic [7:0]             rx_data_q, tx_data_q, rx_sr_q, tx_sr_q, byte_count_q;
  logic                   tx_valid_q, rx_full_q, overrun_q, underrun_q;
  logic [2:0]             bit_cnt_q;

  logic       sclk_s, mosi_s, ncs_s, selected;
  logic       sclk_edge, lead_ev, trail_ev, sample_ev, shift_ev, done_ev, load_ev;
  logic       cpu_rd_data, cpu_wr_data, cpu_wr_status, cpu_wr_ctrl;
  logic [7:0] rx_byte_d, load_byte_d, to_cpu_d;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign selected  = (state_q != IDLE);
  assign to_cpu    = to_cpu_q;
  assign miso      = tx_sr_q[7];
  assign miso_oe   = miso_oe_q;
  assign dbg_state = state_q;
  assign spi_int   = (rx_ie_q & rx_full_q) | (tx_ie_q & ~tx_valid_q);

  // CPU port: a single-cycle strobe (ce) qualifies every access; read data lands one clk later.
  always_comb begin
    cpu_rd_data   = ce && !wren && (a == 2'd0);
    cpu_wr_data   = ce && wren && (a == 2'd0);
    cpu_wr_status = ce && wren && (a == 2'd1);
    cpu_wr_ctrl   = ce && wren && (a == 2'd2);

    sclk_edge = (state_q == SHIFT) && !ncs_s && (sclk_s != sclk_prev_q);
    lead_ev   = sclk_edge && (sclk_s != cpol_q);
    trail_ev  = sclk_edge && (sclk_s == cpol_q);
    sample_ev = cpha_q ? trail_ev : lead_ev;
    // A shift edge with bit_cnt==0 would push out a freshly loaded MSB, so it is skipped.
    shift_ev  = (cpha_q ? lead_ev : trail_ev) && (bit_cnt_q != 3'd0);
    done_ev   = sample_ev && (bit_cnt_q == 3'd7);
    load_ev   = (state_q == SELECT) || done_ev;

    rx_byte_d   = {rx_sr_q[6:0], mosi_s};
    load_byte_d = tx_valid_q ? tx_data_q : IDLE_FILL;

    to_cpu_d = 8'h00;
    case (a)
      2'd0:    to_cpu_d = rx_data_q;
      2'd1:    to_cpu_d = {selected, 3'b000, underrun_q, overrun_q, ~tx_valid_q, rx_full_q};
      2'd2:    to_cpu_d = {4'b0000, tx_ie_q, rx_ie_q, cpha_q, cpol_q};
      default: to_cpu_d = byte_count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      ncs_sync_q   <= '1;
      sclk_prev_q  <= 1'b0;
      to_cpu_q     <= 8'h00;
      miso_oe_q    <= 1'b0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      rx_ie_q      <= 1'b0;
      tx_ie_q      <= 1'b0;
      rx_data_q    <= 8'h00;
      tx_data_q    <= IDLE_FILL;
      rx_sr_q      <= 8'h00;
      tx_sr_q      <= 8'h00;
      byte_count_q <= 8'h00;
      tx_valid_q   <= 1'b0;
      rx_full_q    <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      bit_cnt_q    <= 3'd0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_prev_q <= sclk_s;
      to_cpu_q    <= to_cpu_d;

      case (state_q)
        IDLE: begin
          if (!ncs_s) begin
            state_q   <= SELECT;
            miso_oe_q <= 1'b1;
          end
        end
        SELECT: begin
          bit_cnt_q    <= 3'd0;
          byte_count_q <= 8'h00;
          if (ncs_s) begin
            state_q   <= IDLE;
            miso_oe_q <= 1'b0;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (ncs_s) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            miso_oe_q <= 1'b0;
          end else if (sample_ev) begin
            rx_sr_q   <= rx_byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (shift_ev) tx_sr_q <= {tx_sr_q[6:0], 1'b0};

      // Flag clears come first so a same-clk set event wins.
      if (cpu_wr_status && from_cpu[2]) overrun_q  <= 1'b0;
      if (cpu_wr_status && from_cpu[3]) underrun_q <= 1'b0;

      if (load_ev) begin
        tx_sr_q <= load_byte_d;
        if (!tx_valid_q) underrun_q <= 1'b1;
      end

      if (done_ev) begin
        rx_data_q <= rx_byte_d;
        if (byte_count_q != 8'hFF) byte_count_q <= byte_count_q + 8'd1;
        if (rx_full_q && !cpu_rd_data) overrun_q <= 1'b1;
      end

      if (done_ev)          rx_full_q <= 1'b1;
      else if (cpu_rd_data) rx_full_q <= 1'b0;

      // A reload consumes the pre-write tx byte; a same-clk write stays pending.
      if (cpu_wr_data) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= from_cpu;
      end else if (load_ev) begin
        tx_valid_q <= 1'b0;
      end

      if (cpu_wr_ctrl) begin
        rx_ie_q <= from_cpu[2];
        tx_ie_q <= from_cpu[3];
        if (state_q == IDLE) begin
          cpol_q <= from_cpu[0];
          cpha_q <= from_cpu[1];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ri.sv
// Bench for spi_slave_ri: drives an SPI master model and the CPU port, with queues holding
// the bytes each side is expected to receive.
module tb_spi_slave_ri;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] a;
  logic       ce, wren;
  logic [7:0] from_cpu, to_cpu;
  logic       spi_int;
  logic       sclk, mosi, ncs;
  logic       miso, miso_oe;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] miso_q[$];

  logic cpol_m = 1'b0;
  logic cpha_m = 1'b0;

  spi_slave_ri dut (
    .clk(clk), .reset(reset), .a(a), .ce(ce), .wren(wren), .from_cpu(from_cpu),
    .to_cpu(to_cpu), .spi_int(spi_int), .sclk(sclk), .mosi(mosi), .ncs(ncs),
    .miso(miso), .miso_oe(miso_oe), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // CPU driver tasks
  task automatic cpu_wr(input logic [1:0] addr, input logic [7:0] d);
    @(negedge clk);
    a = addr; from_cpu = d; ce = 1'b1; wren = 1'b1;
    @(negedge clk);
    ce = 1'b0; wren = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] addr, output logic [7:0] d);
    @(negedge clk);
    a = addr; ce = 1'b1; wren = 1'b0;
    @(negedge clk);
    ce = 1'b0;
    d = to_cpu;
  endtask

  task automatic rd_data_check(input string tag);
    logic [7:0] v;
    cpu_rd(2'd0, v);
    check(tag, v, exp_q.pop_front());
  endtask

  // SPI master driver tasks
  task automatic set_mode(input logic [1:0] mode, input logic [1:0] ie);
    cpol_m = mode[1];
    cpha_m = mode[0];
    sclk = cpol_m;
    repeat (6) @(negedge clk);
    cpu_wr(2'd2, {4'b0000, ie, cpha_m, cpol_m});
  endtask

  task automatic select_dut();
    ncs = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic deselect_dut();
    ncs = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Read DATA so the access strobe lands on the clk where the sclk edge just driven completes a byte.
  task automatic read_on_event(output logic [7:0] v);
    repeat (2) @(negedge clk);
    a = 2'd0; ce = 1'b1; wren = 1'b0;
    @(negedge clk);
    ce = 1'b0;
    v = to_cpu;
    repeat (HALF - 3) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [7:0] mtx, input int nbits, input bit rd_done,
                          output logic [7:0] mrx, output logic [7:0] rd_val);
    mrx = 8'h00;
    rd_val = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha_m) begin
        mosi = mtx[i];
        repeat (HALF) @(negedge clk);
        sclk = ~cpol_m;
        mrx[i] = miso;
        if (i == 0 && rd_done) read_on_event(rd_val);
        else repeat (HALF) @(negedge clk);
        sclk = cpol_m;
      end else begin
        sclk = ~cpol_m;
        mosi = mtx[i];
        repeat (HALF) @(negedge clk);
        sclk = cpol_m;
        mrx[i] = miso;
        if (i == 0 && rd_done) read_on_event(rd_val);
        else repeat (HALF) @(negedge clk);
      end
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic xfer_check(input logic [7:0] mtx, input logic [7:0] stx_exp,
                            input bit rd_done, output logic [7:0] rd_val);
    logic [7:0] got;
    exp_q.push_back(mtx);
    miso_q.push_back(stx_exp);
    spi_xfer(mtx, 8, rd_done, got, rd_val);
    check("miso_byte", got, miso_q.pop_front());
  endtask

  logic [7:0] v, rdv, dummy;
  logic [7:0] t2_tx[3];
  logic [7:0] t2_rx[3];

  initial begin
    t2_tx = '{8'h11, 8'h22, 8'h33};
    t2_rx = '{8'h81, 8'h42, 8'h24};
    reset = 1'b1; a = 2'd0; ce = 1'b0; wren = 1'b0; from_cpu = 8'h00;
    sclk = 1'b0; mosi = 1'b0; ncs = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_to_cpu", to_cpu, 8'h00);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_miso", miso, 1'b0);
    check("rst_spi_int", spi_int, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    cpu_rd(2'd1, v); check("rst_status", v, 8'h02);
    cpu_rd(2'd2, v); check("rst_control", v, 8'h00);
    cpu_rd(2'd3, v); check("rst_byte_count", v, 8'h00);
    cpu_rd(2'd0, v); check("rst_rx_data", v, 8'h00);

    // Mode 0, preloaded tx, RX interrupt
    set_mode(2'd0, 2'b01);
    cpu_wr(2'd0, 8'h3C);
    check("t1_int_idle", spi_int, 1'b0);
    select_dut();
    check("t1_miso_oe", miso_oe, 1'b1);
    cpu_wr(2'd2, 8'h0F);
    cpu_rd(2'd2, v); check("t1_ctrl_locked", v, 8'h0C);
    cpu_wr(2'd2, 8'h04);
    xfer_check(8'hA5, 8'h3C, 1'b0, dummy);
    check("t1_spi_int", spi_int, 1'b1);
    cpu_rd(2'd3, v); check("t1_byte_count", v, 8'h01);
    deselect_dut();
    check("t1_miso_oe_off", miso_oe, 1'b0);
    cpu_rd(2'd1, v); check("t1_status", v, 8'h0B);
    cpu_wr(2'd1, 8'h08);
    rd_data_check("t1_rx_data");
    check("t1_int_clear", spi_int, 1'b0);
    cpu_rd(2'd1, v); check("t1_status_clr", v, 8'h02);

    // Modes 1..3: three-byte bursts refilled on TX_EMPTY
    for (int m = 1; m <= 3; m++) begin
      set_mode(m[1:0], 2'b00);
      cpu_rd(2'd2, v); check("t2_control", v, {6'b0, m[0], m[1]});
      cpu_wr(2'd0, t2_tx[0]);
      select_dut();
      for (int k = 0; k < 3; k++) begin
        cpu_rd(2'd1, v); check("t2_status_sel", v, 8'h82);
        cpu_wr(2'd0, (k < 2) ? t2_tx[k+1] : 8'h5A);
        xfer_check(t2_rx[k], t2_tx[k], 1'b0, dummy);
        rd_data_check("t2_rx_data");
      end
      deselect_dut();
      cpu_rd(2'd3, v); check("t2_byte_count", v, 8'h03);
      cpu_rd(2'd1, v); check("t2_status_end", v, 8'h02);
    end

    // Underrun sends IDLE_FILL
    set_mode(2'd0, 2'b00);
    select_dut();
    xfer_check(8'h00, 8'hFF, 1'b0, dummy);
    deselect_dut();
    cpu_rd(2'd1, v); check("t3_status", v, 8'h0B);
    cpu_wr(2'd1, 8'h08);
    cpu_rd(2'd1, v); check("t3_status_clr", v, 8'h03);
    rd_data_check("t3_rx_data");

    // Overrun, then a DATA read on the completion clk
    select_dut();
    xfer_check(8'h55, 8'hFF, 1'b0, dummy);
    xfer_check(8'hAA, 8'hFF, 1'b0, dummy);
    cpu_rd(2'd1, v); check("t4_status_ovr", v, 8'h8F);
    void'(exp_q.pop_front());
    rd_data_check("t4_rx_data_ovr");
    cpu_wr(2'd1, 8'h0C);
    cpu_rd(2'd1, v); check("t4_status_clr", v, 8'h82);
    xfer_check(8'h55, 8'hFF, 1'b0, dummy);
    xfer_check(8'hAA, 8'hFF, 1'b1, rdv);
    check("t4_rd_on_done", rdv, exp_q.pop_front());
    cpu_rd(2'd1, v); check("t4_status_race", v, 8'h8B);
    rd_data_check("t4_rx_data_race");
    deselect_dut();
    cpu_wr(2'd1, 8'h0C);

    // Abort after 5 bits, then a clean byte
    cpu_wr(2'd0, 8'h77);
    select_dut();
    spi_xfer(8'hFF, 5, 1'b0, dummy, rdv);
    deselect_dut();
    cpu_rd(2'd1, v); check("t5_status_abort", v, 8'h02);
    cpu_rd(2'd3, v); check("t5_byte_count", v, 8'h00);
    cpu_wr(2'd0, 8'h69);
    select_dut();
    xfer_check(8'h96, 8'h69, 1'b0, dummy);
    deselect_dut();
    rd_data_check("t5_rx_data");
    cpu_rd(2'd3, v); check("t5_byte_count2", v, 8'h01);
    cpu_wr(2'd1, 8'h0C);

    // Asynchronous reset mid-byte
    cpu_wr(2'd2, 8'h04);
    select_dut();
    spi_xfer(8'hC3, 3, 1'b0, dummy, rdv);
    cpu_rd(2'd2, v); check("t6_ctrl_pre", v, 8'h04);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_to_cpu", to_cpu, 8'h00);
    check("t6_miso_oe", miso_oe, 1'b0);
    check("t6_state", dbg_state, 2'd0);
    ncs = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    cpu_rd(2'd1, v); check("t6_status", v, 8'h02);
    cpu_rd(2'd2, v); check("t6_control", v, 8'h00);
    cpu_rd(2'd3, v); check("t6_byte_count", v, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
